// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, oversampling constants
// and the bit-vote helpers used by the oversampling receiver.
package uart_pkg;

  localparam int OVS = 16;
  localparam logic [4:0] LAST_TICK     = 5'(OVS - 1);
  localparam logic [4:0] VOTE_IDX0     = 5'd7;
  localparam logic [4:0] VOTE_IDX1     = 5'd8;
  localparam logic [4:0] VOTE_IDX2     = 5'd9;
  localparam logic [4:0] MID_START_IDX = 5'd7;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_START    = 3'd1,
    ST_DATA     = 3'd2,
    ST_STOP     = 3'd3,
    ST_BRK_WAIT = 3'd4
  } rx_state_e;

  function automatic logic maj3(input logic [2:0] v);
    return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
  endfunction

  // Loads the vote slot belonging to the current tick index; other ticks leave v untouched.
  function automatic logic [2:0] vote_capture(input logic [2:0] v, input logic [4:0] s,
                                              input logic bit_val);
    logic [2:0] r;
    r = v;
    case (s)
      VOTE_IDX0: r[0] = bit_val;
      VOTE_IDX1: r[1] = bit_val;
      VOTE_IDX2: r[2] = bit_val;
      default:   r = v;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for an asynchronous single-bit input; the reset value
// should match the idle level of the pin it guards.
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/uart_rx_os.sv
// 16x oversampling UART receiver with false-start rejection, 3-sample majority
// vote per bit, framing-error flag and break detection.
module uart_rx_os
  import uart_pkg::*;
#(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       s_tick,
  input  logic       rx,
  output logic [7:0] dout,
  output logic       rx_done_tick,
  output logic       frame_err,
  output logic       break_tick
);

  localparam logic [4:0] STOP_LAST = 5'(SB_TICK - 1);
  localparam logic [2:0] N_LAST    = 3'(DBIT - 1);
  localparam int         SHIFT     = 8 - DBIT;

  logic       rxs;
  logic       maj;
  rx_state_e  state_q, state_d;
  logic [4:0] s_q, s_d;
  logic [2:0] n_q, n_d;
  logic [7:0] b_q, b_d;
  logic [2:0] v_q, v_d;
  logic [7:0] dout_q, dout_d;
  logic       done_q, done_d;
  logic       fe_q, fe_d;
  logic       brk_q, brk_d;

  sync_2ff #(.RST_VAL(1'b1)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (rx),
    .q     (rxs)
  );

  assign maj = maj3(v_q);

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    n_d     = n_q;
    b_d     = b_q;
    v_d     = v_q;
    dout_d  = dout_q;
    fe_d    = fe_q;
    done_d  = 1'b0;
    brk_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!rxs) begin
          state_d = ST_START;
          s_d     = 5'd0;
          b_d     = 8'd0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_START: begin
        if (s_tick) begin
          if ((s_q == MID_START_IDX) && rxs) begin
            state_d = ST_IDLE;
          end else if (s_q == LAST_TICK) begin
            s_d     = 5'd0;
            n_d     = 3'd0;
            state_d = ST_DATA;
          end else begin
            s_d = s_q + 5'd1;
          end
        end else begin
          state_d = ST_START;
        end
      end
      ST_DATA: begin
        if (s_tick) begin
          v_d = vote_capture(v_q, s_q, rxs);
          if (s_q == LAST_TICK) begin
            b_d = {maj, b_q[7:1]};
            s_d = 5'd0;
            if (n_q == N_LAST) begin
              state_d = ST_STOP;
            end else begin
              n_d = n_q + 3'd1;
            end
          end else begin
            s_d = s_q + 5'd1;
          end
        end else begin
          state_d = ST_DATA;
        end
      end
      ST_STOP: begin
        if (s_tick) begin
          v_d = vote_capture(v_q, s_q, rxs);
          if (s_q == STOP_LAST) begin
            // Data sits in the top DBIT bits of b; shift down to right-justify.
            dout_d = b_q >> SHIFT;
            fe_d   = ~maj;
            done_d = 1'b1;
            s_d    = 5'd0;
            if (!maj && (b_q == 8'd0)) begin
              brk_d   = 1'b1;
              state_d = ST_BRK_WAIT;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            s_d = s_q + 5'd1;
          end
        end else begin
          state_d = ST_STOP;
        end
      end
      ST_BRK_WAIT: begin
        if (rxs) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_BRK_WAIT;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      s_q     <= 5'd0;
      n_q     <= 3'd0;
      b_q     <= 8'd0;
      v_q     <= 3'd0;
      dout_q  <= 8'd0;
      done_q  <= 1'b0;
      fe_q    <= 1'b0;
      brk_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      n_q     <= n_d;
      b_q     <= b_d;
      v_q     <= v_d;
      dout_q  <= dout_d;
      done_q  <= done_d;
      fe_q    <= fe_d;
      brk_q   <= brk_d;
    end
  end

  assign dout         = dout_q;
  assign rx_done_tick = done_q;
  assign frame_err    = fe_q;
  assign break_tick   = brk_q;

endmodule
